// File: rtl/dp_arbiter.sv
// dp_arbiter: shares one dot_product engine between two requesters. Each job is
//   granted whole, and that requester's A/B/C streams are steered to the engine.
// Latency: 1 cycle from job handshake to the first stream beat. The A/B/C paths
//   are combinational pass-through, and IDLE lasts at least 1 cycle between jobs.
// Backpressure: engine ready and requester c_ready pass straight through. A pending
//   job request waits in IDLE and is never dropped. A held result blocks new grants.
// Ports: clk/rst (sync, active-high); job<i>_len/valid/ready form the job-start
//   handshake. a<i>_*, b<i>_* are operand streams and c<i>_* is the result stream.
//   dp_* is the engine side. busy is high outside IDLE. grant_id is the current or
//   last owner.
// Build option: define DP_ARB_RR_EN for round-robin ties. Without it, ties are
//   fixed priority to requester 0.
module dp_arbiter #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] job0_len,
  input  logic             job0_valid,
  output logic             job0_ready,
  input  logic [LEN_W-1:0] job1_len,
  input  logic             job1_valid,
  output logic             job1_ready,
  input  logic [WIDTH-1:0] a0_data,
  input  logic             a0_valid,
  output logic             a0_ready,
  input  logic [WIDTH-1:0] b0_data,
  input  logic             b0_valid,
  output logic             b0_ready,
  output logic [WIDTH-1:0] c0_data,
  output logic             c0_valid,
  input  logic             c0_ready,
  input  logic [WIDTH-1:0] a1_data,
  input  logic             a1_valid,
  output logic             a1_ready,
  input  logic [WIDTH-1:0] b1_data,
  input  logic             b1_valid,
  output logic             b1_ready,
  output logic [WIDTH-1:0] c1_data,
  output logic             c1_valid,
  input  logic             c1_ready,
  output logic [LEN_W-1:0] dp_len,
  output logic [WIDTH-1:0] dp_a_data,
  output logic             dp_a_valid,
  input  logic             dp_a_ready,
  output logic [WIDTH-1:0] dp_b_data,
  output logic             dp_b_valid,
  input  logic             dp_b_ready,
  input  logic [WIDTH-1:0] dp_c_data,
  input  logic             dp_c_valid,
  output logic             dp_c_ready,
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {IDLE, STREAM, RESULT, ZERO} state_t;

  state_t           state, state_nxt;
  logic             ptr;
  logic [LEN_W:0]   a_cnt, b_cnt;
  logic [LEN_W:0]   len_ext;
  logic             win;
  logic [LEN_W-1:0] win_len;
  logic             job_fire, a_fire, b_fire, done;
  logic             a_open, b_open;
  logic             sel_a_valid, sel_b_valid, sel_c_ready;
  logic [WIDTH-1:0] sel_a_data, sel_b_data;

  // When both request, the pointer breaks the tie. Otherwise the lone requester wins.
  assign win     = (job0_valid && job1_valid) ? ptr : job1_valid;
  assign win_len = win ? job1_len : job0_len;

  // Inputs of the granted requester.
  assign sel_a_valid = grant_id ? a1_valid : a0_valid;
  assign sel_a_data  = grant_id ? a1_data  : a0_data;
  assign sel_b_valid = grant_id ? b1_valid : b0_valid;
  assign sel_b_data  = grant_id ? b1_data  : b0_data;
  assign sel_c_ready = grant_id ? c1_ready : c0_ready;

  // A channel closes when its count reaches the job length, so counters never wrap.
  assign len_ext = {1'b0, dp_len};
  assign a_open  = (state == STREAM) && (a_cnt < len_ext);
  assign b_open  = (state == STREAM) && (b_cnt < len_ext);

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    job0_ready = 1'b0;
    job1_ready = 1'b0;
    a0_ready   = 1'b0;
    a1_ready   = 1'b0;
    b0_ready   = 1'b0;
    b1_ready   = 1'b0;
    c0_valid   = 1'b0;
    c1_valid   = 1'b0;
    c0_data    = '0;
    c1_data    = '0;
    dp_a_valid = 1'b0;
    dp_a_data  = '0;
    dp_b_valid = 1'b0;
    dp_b_data  = '0;
    dp_c_ready = 1'b0;
    job_fire   = 1'b0;
    a_fire     = 1'b0;
    b_fire     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (job0_valid || job1_valid) begin
          job_fire = 1'b1;
          if (win) job1_ready = 1'b1;
          else     job0_ready = 1'b1;
          state_nxt = (win_len == '0) ? ZERO : STREAM;
        end
      end
      STREAM: begin
        if (a_open) begin
          dp_a_valid = sel_a_valid;
          dp_a_data  = sel_a_data;
          if (grant_id) a1_ready = dp_a_ready;
          else          a0_ready = dp_a_ready;
          a_fire = sel_a_valid && dp_a_ready;
        end
        if (b_open) begin
          dp_b_valid = sel_b_valid;
          dp_b_data  = sel_b_data;
          if (grant_id) b1_ready = dp_b_ready;
          else          b0_ready = dp_b_ready;
          b_fire = sel_b_valid && dp_b_ready;
        end
        if ((a_cnt == len_ext) && (b_cnt == len_ext)) state_nxt = RESULT;
      end
      RESULT: begin
        dp_c_ready = sel_c_ready;
        if (grant_id) begin
          c1_valid = dp_c_valid;
          c1_data  = dp_c_data;
        end else begin
          c0_valid = dp_c_valid;
          c0_data  = dp_c_data;
        end
        if (dp_c_valid && sel_c_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      ZERO: begin
        // The engine is bypassed. The result is a constant zero.
        if (grant_id) c1_valid = 1'b1;
        else          c0_valid = 1'b1;
        if (sel_c_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      a_cnt    <= '0;
      b_cnt    <= '0;
      dp_len   <= '0;
      grant_id <= 1'b0;
    end else begin
      state <= state_nxt;
      if (job_fire) begin
        dp_len   <= win_len;
        grant_id <= win;
        a_cnt    <= '0;
        b_cnt    <= '0;
      end else begin
        if (a_fire) a_cnt <= a_cnt + (LEN_W+1)'(1);
        if (b_fire) b_cnt <= b_cnt + (LEN_W+1)'(1);
      end
      if (done) begin
`ifdef DP_ARB_RR_EN
        ptr <= ~grant_id;
`else
        ptr <= 1'b0;
`endif
      end
    end
  end

endmodule
